aes_key_sched_ctrl: RTL and testbench

Sequencer for the AES-128 key expansion datapath. It loads a cipher key, drives the single-round expander through ten rounds with the correct round constant, and waits the expander's settle time each round. It captures all eleven round keys into an internal store and serves them to the encryption core through a registered read port. It sits between the key input interface and the round pipeline.

---
 rtl/aes_key_sched_ctrl.sv | 158 +++++++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl: AES-128 key expansion sequencer.
// Loads a cipher key and steps an external single-round expander through
// ten rounds, waiting SETTLE_CYCLES per round. It captures the eleven round
// keys into a local store and serves them through a registered read port.
// Optional feature: define KEY_SCHED_CACHE_EN to skip re-expansion when the
// requested key matches the last fully expanded key.
module aes_key_sched_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  output logic         busy,
  output logic         done,
  output logic         rk_valid,
  output logic [127:0] exp_key_in,
  output logic [31:0]  exp_rcon,
  input  logic [127:0] exp_key_out,
  input  logic [3:0]   rk_addr,
  output logic [127:0] rk_data
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CAPTURE
  } state_t;

  localparam logic [7:0] CNT_RELOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [3:0] LAST_ROUND = 4'd10;

  state_t         state;
  logic [3:0]     round;
  logic [7:0]     cnt;
  logic [7:0]     rcon_q;
  logic [127:0]   rk [11];
  logic           cache_hit;

  // AES round constant for rounds 1..10; zero outside that range.
  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    logic [7:0] v;
    v = 8'h00;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1B;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  assign exp_rcon = {24'h000000, rcon_q};

`ifdef KEY_SCHED_CACHE_EN
  logic [127:0] cache_key;
  logic         cache_valid;

  // A hit needs both a valid cache entry and a complete store behind it.
  assign cache_hit = cache_valid && rk_valid && (key == cache_key);

  // Cache tracks the key of the last completed expansion; any miss start
  // invalidates it until the new expansion finishes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_valid <= 1'b0;
      cache_key   <= '0;
    end else if (state == IDLE && start && !cache_hit) begin
      cache_valid <= 1'b0;
    end else if (state == CAPTURE && round == LAST_ROUND) begin
      cache_valid <= 1'b1;
      cache_key   <= rk[0];
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  // Sequencer: load key, wait for expander, capture, repeat for ten rounds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      round      <= 4'd0;
      cnt        <= 8'd0;
      rcon_q     <= 8'h00;
      busy       <= 1'b0;
      done       <= 1'b0;
      rk_valid   <= 1'b0;
      exp_key_in <= '0;
      for (int unsigned i = 0; i < 11; i++) begin
        rk[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (cache_hit) begin
              done <= 1'b1;
            end else begin
              rk[0]      <= key;
              exp_key_in <= key;
              round      <= 4'd1;
              cnt        <= CNT_RELOAD;
              rcon_q     <= rcon_of(4'd1);
              rk_valid   <= 1'b0;
              busy       <= 1'b1;
              state      <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 8'd0) begin
            state <= CAPTURE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        CAPTURE: begin
          rk[round]  <= exp_key_out;
          exp_key_in <= exp_key_out;
          if (round == LAST_ROUND) begin
            done     <= 1'b1;
            rk_valid <= 1'b1;
            busy     <= 1'b0;
            rcon_q   <= 8'h00;
            state    <= IDLE;
          end else begin
            round  <= round + 4'd1;
            cnt    <= CNT_RELOAD;
            rcon_q <= rcon_of(round + 4'd1);
            state  <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered read port; addresses past round 10 read as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rk_data <= '0;
    end else if (rk_addr <= LAST_ROUND) begin
      rk_data <= rk[rk_addr];
    end else begin
      rk_data <= '0;
    end
  end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Testbench for aes_key_sched_ctrl: behavioural AES key expander with a
// settle window, table-driven read checks through a scoreboard queue, and
// hand-written sequences for ignored start, mid-run reset and caching.
module tb_aes_key_sched_ctrl;

  localparam int unsigned SETTLE = 20;
  localparam int unsigned FULL_CYCLES = 10 * (SETTLE + 1);
  localparam int unsigned NONE = 32'hFFFF_FFFF;
`ifdef KEY_SCHED_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K3 = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] K1_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K1_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] key;
  logic         busy;
  logic         done;
  logic         rk_valid;
  logic [127:0] exp_key_in;
  logic [31:0]  exp_rcon;
  logic [127:0] exp_key_out;
  logic [3:0]   rk_addr;
  logic [127:0] rk_data;

  int unsigned checks = 0;
  int unsigned errors = 0;

  aes_key_sched_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .key        (key),
    .busy       (busy),
    .done       (done),
    .rk_valid   (rk_valid),
    .exp_key_in (exp_key_in),
    .exp_rcon   (exp_rcon),
    .exp_key_out(exp_key_out),
    .rk_addr    (rk_addr),
    .rk_data    (rk_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [0:255][7:0] sbox = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

  function automatic logic [127:0] next_rk(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t = {sbox[w3[23:16]], sbox[w3[15:8]], sbox[w3[7:0]], sbox[w3[31:24]]} ^ {rc, 24'h000000};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Expander model: output is corrupted until SETTLE cycles after any input change.
  logic [127:0] prev_in = '0;
  logic [7:0]   prev_rc = '0;
  int unsigned  settle = 0;
  always @(negedge clk) begin
    if (exp_key_in !== prev_in || exp_rcon[7:0] !== prev_rc) begin
      settle  = 0;
      prev_in = exp_key_in;
      prev_rc = exp_rcon[7:0];
    end else if (settle < 1000) begin
      settle++;
    end
    if (settle >= SETTLE) exp_key_out = next_rk(exp_key_in, exp_rcon[7:0]);
    else                  exp_key_out = next_rk(exp_key_in, exp_rcon[7:0]) ^ {4{32'hA5A55A5A}};
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]   addr;
    logic [127:0] data;
  } read_vec_t;

  read_vec_t rv [16];
  read_vec_t sb [$];
  logic [127:0] sched [11];

  task automatic build_sched(input logic [127:0] k);
    sched[0] = k;
    for (int unsigned i = 1; i < 11; i++) sched[i] = next_rk(sched[i-1], rcon_tab[i-1]);
  endtask

  // Apply the first n read vectors; expected data is queued at drive time.
  task automatic read_table(input int unsigned n);
    read_vec_t e;
    for (int unsigned i = 0; i <= n; i++) begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk($sformatf("rd_addr%0d", e.addr), rk_data, e.data);
      end
      if (i < n) begin
        rk_addr = rv[i].addr;
        sb.push_back(rv[i]);
      end
    end
  endtask

  // Issue a start and follow the run; optional ignored start at poke_at and
  // reset at rst_at (NONE disables either).
  task automatic run_start(input string tag, input logic [127:0] k, input bit hit,
                           input int unsigned poke_at, input logic [127:0] poke_key,
                           input int unsigned rst_at);
    int unsigned seen = NONE;
    int unsigned dones = 0;
    int unsigned rcon_err = 0, key_err = 0, busy_err = 0;
    int unsigned r;
    build_sched(k);
    @(negedge clk);
    key   = k;
    start = 1'b1;
    for (int unsigned kk = 0; kk < FULL_CYCLES + 50; kk++) begin
      @(negedge clk);
      if (kk == 0) start = 1'b0;
      if (kk == poke_at) begin
        start = 1'b1;
        key   = poke_key;
      end else if (kk == poke_at + 1) begin
        start = 1'b0;
      end
      if (kk == rst_at) begin
        chk({tag, "_no_done_before_rst"}, 128'(dones), 128'd0);
        rst = 1'b1;
        #1;
        chk({tag, "_rst_busy"}, 128'(busy), 128'd0);
        chk({tag, "_rst_valid"}, 128'(rk_valid), 128'd0);
        chk({tag, "_rst_rcon"}, 128'(exp_rcon), 128'd0);
        chk({tag, "_rst_keyin"}, exp_key_in, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
          @(negedge clk);
          if (done) dones++;
        end
        chk({tag, "_no_done_after_rst"}, 128'(dones), 128'd0);
        return;
      end
      if (done) begin
        dones++;
        if (seen == NONE) begin
          seen = kk;
          chk({tag, "_done_busy"}, 128'(busy), 128'd0);
          chk({tag, "_done_valid"}, 128'(rk_valid), 128'd1);
          chk({tag, "_done_rcon"}, 128'(exp_rcon), 128'd0);
          if (!hit) chk({tag, "_done_keyin"}, exp_key_in, sched[10]);
        end
      end
      if (hit) begin
        if (busy !== 1'b0) busy_err++;
      end else if (seen == NONE && kk < FULL_CYCLES) begin
        r = kk / (SETTLE + 1);
        if (exp_rcon !== {24'h000000, rcon_tab[r]}) rcon_err++;
        if (exp_key_in !== sched[r]) key_err++;
        if (busy !== 1'b1) busy_err++;
      end
      if (seen != NONE && kk == seen + 1) chk({tag, "_done_one_cycle"}, 128'(done), 128'd0);
      if (seen != NONE && kk >= seen + 20) break;
    end
    chk({tag, "_done_cycle"}, 128'(seen), hit ? 128'd0 : 128'(FULL_CYCLES));
    chk({tag, "_done_count"}, 128'(dones), 128'd1);
    chk({tag, "_busy"}, 128'(busy_err), 128'd0);
    if (!hit) begin
      chk({tag, "_rcon_seq"}, 128'(rcon_err), 128'd0);
      chk({tag, "_keyin_seq"}, 128'(key_err), 128'd0);
    end
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    key     = '0;
    rk_addr = 4'd0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_done", 128'(done), 128'd0);
    chk("reset_valid", 128'(rk_valid), 128'd0);
    chk("reset_rkdata", rk_data, 128'd0);
    chk("reset_rcon", 128'(exp_rcon), 128'd0);
    chk("reset_keyin", exp_key_in, 128'd0);
    rst = 1'b0;
    @(negedge clk);

    // Known-answer expansion and table-driven reads.
    run_start("k1", K1, 1'b0, NONE, '0, NONE);
    build_sched(K1);
    rv[0]  = '{4'd0,  K1};
    rv[1]  = '{4'd1,  K1_RK1};
    rv[2]  = '{4'd10, K1_RK10};
    rv[3]  = '{4'd11, 128'd0};
    rv[4]  = '{4'd2,  sched[2]};
    rv[5]  = '{4'd15, 128'd0};
    rv[6]  = '{4'd5,  sched[5]};
    rv[7]  = '{4'd9,  sched[9]};
    rv[8]  = '{4'd3,  sched[3]};
    rv[9]  = '{4'd12, 128'd0};
    rv[10] = '{4'd7,  sched[7]};
    read_table(11);

    // Address change takes effect exactly one cycle later.
    rk_addr = 4'd1;
    @(negedge clk);
    chk("lat_before", rk_data, K1_RK1);
    rk_addr = 4'd10;
    #1;
    chk("lat_hold", rk_data, K1_RK1);
    @(negedge clk);
    chk("lat_after", rk_data, K1_RK10);

    // Start during expansion with a different key is ignored.
    run_start("k2poke", K2, 1'b0, 50, K3, NONE);
    build_sched(K2);
    rv[0] = '{4'd0,  K2};
    rv[1] = '{4'd6,  sched[6]};
    rv[2] = '{4'd10, sched[10]};
    read_table(3);

    // Reset mid-expansion clears the store; next run completes normally.
    run_start("k1rst", K1, 1'b0, NONE, '0, 100);
    for (int unsigned i = 0; i < 11; i++) rv[i] = '{4'(i), 128'd0};
    read_table(11);
    chk("post_rst_valid", 128'(rk_valid), 128'd0);
    run_start("k1again", K1, 1'b0, NONE, '0, NONE);
    rv[0] = '{4'd10, K1_RK10};
    read_table(1);

    // Repeat key: skipped when caching is built in, full run otherwise.
    run_start("k1repeat", K1, CACHE, NONE, '0, NONE);
    chk("repeat_valid", 128'(rk_valid), 128'd1);
    rv[0] = '{4'd1,  K1_RK1};
    rv[1] = '{4'd10, K1_RK10};
    read_table(2);

    // New key always runs the full expansion.
    run_start("k3new", K3, 1'b0, NONE, '0, NONE);
    build_sched(K3);
    rv[0] = '{4'd10, sched[10]};
    rv[1] = '{4'd4,  sched[4]};
    read_table(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
